// File: rtl/adder_arb.sv
// adder_arb: round-robin scheduler sharing one pipelined 2-input adder among
// NUM requesters. Each grant's requester ID rides a tag pipeline matched to the
// adder latency, and the returning sum is registered together with that ID.
// Optional build macro ADDER_ARB_ERR_EN adds a sticky checker on err that flags
// any cycle where the adder's valid_out disagrees with the tag pipeline tail.
module adder_arb #(
    parameter int BITS    = 8,
    parameter int NUM     = 4,
    parameter int LATENCY = 1,
    parameter int IDW     = $clog2(NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NUM-1:0]        req_valid,
    output logic [NUM-1:0]        req_ready,
    input  logic [NUM*BITS-1:0]   req_i0,
    input  logic [NUM*BITS-1:0]   req_i1,
    output logic                  add_valid,
    output logic [BITS-1:0]       add_i0,
    output logic [BITS-1:0]       add_i1,
    input  logic [BITS-1:0]       add_o,
    input  logic                  add_valid_out,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [BITS-1:0]       rsp_data,
    output logic                  err
);

    // Requester index reached by stepping 'off' places past 'base', modulo NUM.
    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM) begin
            s = s - NUM;
        end
        return s[IDW-1:0];
    endfunction

    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  ptr_d;
    logic            found;
    logic [IDW-1:0]  grant_id;
    logic            grant;
    logic [BITS-1:0] op0_arr [NUM];
    logic [BITS-1:0] op1_arr [NUM];

    logic            tv_q  [LATENCY];
    logic [IDW-1:0]  tid_q [LATENCY];
    logic            tail_tv;
    logic [IDW-1:0]  tail_tid;
    logic            rsp_fire;

    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [BITS-1:0] rsp_data_q;

    // Unpack the flat operand buses into per-requester lanes.
    generate
        for (genvar gi = 0; gi < NUM; gi++) begin : g_unpack
            assign op0_arr[gi] = req_i0[gi*BITS +: BITS];
            assign op1_arr[gi] = req_i1[gi*BITS +: BITS];
        end
    endgenerate

    // Round-robin search: first valid requester starting at ptr, wrapping.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        for (int off = 0; off < NUM; off++) begin
            if (!found && req_valid[rr_index(ptr_q, off)]) begin
                found    = 1'b1;
                grant_id = rr_index(ptr_q, off);
            end
        end
    end

    assign grant = en & found;

    // Grant decode and operand issue; outputs are zero when nothing is granted.
    always_comb begin
        req_ready = '0;
        add_i0    = '0;
        add_i1    = '0;
        ptr_d     = ptr_q;
        if (grant) begin
            req_ready[grant_id] = 1'b1;
            add_i0              = op0_arr[grant_id];
            add_i1              = op1_arr[grant_id];
            ptr_d               = (grant_id == IDW'(NUM - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    assign add_valid = grant;

    // Priority pointer: moves one past the last granted requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Tag pipeline carrying {valid, requester ID} alongside the adder.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                tv_q[i]  <= 1'b0;
                tid_q[i] <= '0;
            end
        end else begin
            tv_q[0]  <= grant;
            tid_q[0] <= grant ? grant_id : '0;
            for (int i = 1; i < LATENCY; i++) begin
                tv_q[i]  <= tv_q[i-1];
                tid_q[i] <= tid_q[i-1];
            end
        end
    end

    assign tail_tv  = tv_q[LATENCY-1];
    assign tail_tid = tid_q[LATENCY-1];
    assign rsp_fire = add_valid_out & tail_tv;

    // Response register; ID and data hold their last value between results.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_fire;
            if (rsp_fire) begin
                rsp_id_q   <= tail_tid;
                rsp_data_q <= add_o;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

`ifdef ADDER_ARB_ERR_EN
    localparam int MW = $clog2(LATENCY + 1);
    logic [MW-1:0] mask_q;
    logic          err_q;

    // Sticky mismatch checker, blind for LATENCY cycles after reset so that
    // results already inside the adder at reset time are not flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= MW'(LATENCY);
            err_q  <= 1'b0;
        end else begin
            if (mask_q != '0) begin
                mask_q <= mask_q - 1'b1;
            end else if (add_valid_out != tail_tv) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/adder_arb.md
Name: adder_arb

Overview:
- Round-robin arbiter and scheduler that shares one external pipelined 2-input adder (adder__bits*_num2 style: valid in, o/valid_out out, fixed latency) among NUM requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The block issues at most one operation per cycle, tracks the requester ID through the adder latency, and returns each sum tagged with its requester ID.
- Sits between requesting datapath units and the shared adder instance.

Parameters:
- BITS, 8, operand/result width.
- NUM, 4, number of requesters (2..16).
- LATENCY, 1, adder cycles from valid to valid_out (1..8).
- IDW, $clog2(NUM), width of the requester ID.

Ports:
- clk  input  1  clock; one clock, clk.
- rst  input  1  reset; synchronous, active-high.
- en  input  1  grant enable; 0 = no new grants.
- req_valid  input  NUM  per-requester request.
- req_ready  output  NUM  per-requester accept (one-hot or zero).
- req_i0  input  NUM*BITS  operand 0; requester k in bits [k*BITS +: BITS].
- req_i1  input  NUM*BITS  operand 1, same packing.
- add_valid  output  1  issue to adder.
- add_i0  output  BITS  adder operand 0.
- add_i1  output  BITS  adder operand 1.
- add_o  input  BITS  adder sum.
- add_valid_out  input  1  adder result valid.
- rsp_valid  output  1  result valid (registered).
- rsp_id  output  IDW  requester ID of result.
- rsp_data  output  BITS  sum.
- err  output  1  sticky protocol error (feature only, else tied 0).

Behaviour:
- Arbitration (combinational):
  - Candidate = first k with req_valid[k]=1, searching ptr, ptr+1, ..., wrapping modulo NUM.
  - When en=1 and a candidate exists: req_ready[k]=1, add_valid=1, add_i0/add_i1 = requester k operands. Transfer on req_valid[k] & req_ready[k].
  - Otherwise req_ready=0, add_valid=0, add_i0/add_i1=0.
  - req_ready depends combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- Pointer:
  - Registered ptr, reset 0.
  - After a grant to k: ptr <= (k+1) mod NUM, wrapping from NUM-1 to 0.
  - No grant: ptr holds.
- Tag pipeline:
  - LATENCY-deep shift register of {tv, tid}, reset all 0.
  - Each cycle, stage 0 <= {add_valid, granted k}.
  - Tail = stage LATENCY-1.
- Response (registered; total latency handshake -> rsp_valid = LATENCY+1 cycles):
  - rsp_valid <= add_valid_out & tail.tv.
  - rsp_id <= tail.tid; rsp_data <= add_o.
  - rsp_id and rsp_data hold their last value when rsp_valid=0.
  - Reset values: rsp_valid=0, rsp_id=0, rsp_data=0.
- No response backpressure: sinks must accept every rsp_valid cycle.
- Sum width is BITS; overflow wraps modulo 2^BITS, same as the adder.
- Throughput: one grant per cycle with back-to-back grants allowed; with all NUM requesting continuously, each requester is granted exactly once per NUM cycles.
- Boundaries:
  - en falls while requests are pending: no new grants; in-flight results still return.
  - Single requester continuously valid: granted every cycle.
  - add_valid_out with tail.tv=0: dropped, no rsp.
  - tail.tv=1 without add_valid_out: result lost, no rsp.
  - rst mid-operation: ptr, tag pipeline, rsp and err cleared next edge. Results returning afterwards meet tv=0 and are dropped.

Optional Feature:
- Macro ADDER_ARB_ERR_EN.
- Defined:
  - err is set sticky when add_valid_out != tail.tv in any cycle.
  - err is masked for LATENCY cycles after rst deasserts.
  - err is cleared only by rst.
- Undefined: no checker logic; err tied 0. Datapath behaviour is identical in both builds.

Test Plan:
- NUM=4, LATENCY=1, reset then all four valid with operand pairs (k+1, 10*k) held 8 cycles -> grant order 0,1,2,3,0,1,2,3. rsp stream starts 2 cycles after first grant: ids 0,1,2,3 with data 1, 12, 23, 34, repeating.
- Only requester 2 valid, i0=200, i1=100 -> granted every cycle; rsp_data=44 (wrap of 300), rsp_id=2.
- Requesters 1 and 3 valid, ptr=2 -> grant 3 first, then 1, alternating.
- en=0 for 3 cycles with requests pending -> req_ready=0, add_valid=0; results already in flight still appear on rsp; grants resume from the held ptr when en=1.
- rst pulsed one cycle while 1 result is in flight (LATENCY=3) -> after rst: rsp_valid stays 0 for the stale add_valid_out, ptr=0, err=0.
- ADDER_ARB_ERR_EN defined, model drops one add_valid_out -> err=1 next cycle and stays 1 until rst. Macro undefined, same stimulus -> err=0.
